regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the single register-file write port (RegWr/Rw/busW) between two writeback sources:
//   port 0 = main pipeline WB, port 1 = multi-cycle unit (mul/div, load miss).
//   Fixed priority to port 0, with an anti-starvation counter that forces a port-1 grant.
//   Keeps a 32-bit pending scoreboard of registers owed a write by port 1, used by issue/hazard logic.
// PARAMETERS
//   MAX_WAIT   4   cycles port 1 may be refused before it gets forced priority (>=1)
//   CW         3   wait counter width, must hold MAX_WAIT ($clog2(MAX_WAIT+1))
// PORTS
//   clk           in   1   clock, all state updates on rising edge
//   rst_n         in   1   asynchronous reset, active low
//   wb0_valid     in   1   port 0 has a write
//   wb0_ready     out  1   port 0 write accepted this cycle (combinational)
//   wb0_rd        in   5   port 0 destination register
//   wb0_data      in   32  port 0 write data
//   wb1_valid     in   1   port 1 has a write
//   wb1_ready     out  1   port 1 write accepted this cycle (combinational)
//   wb1_rd        in   5   port 1 destination register
//   wb1_data      in   32  port 1 write data
//   iss_valid     in   1   op issued to multi-cycle unit, reserves iss_rd
//   iss_rd        in   5   destination register of issued op
//   iss_ready     out  1   reservation accepted (combinational)
//   RegWr         out  1   register-file write enable (registered)
//   Rw            out  5   register-file write address (registered)
//   busW          out  32  register-file write data (registered)
//   pending_mask  out  32  bit r = 1: r awaits a port-1 write
// BEHAVIOUR
//   Transfer on port N = wbN_valid & wbN_ready.
//   force1 = (wait_cnt >= MAX_WAIT).
//   wb0_ready = ~(force1 & wb1_valid).
//   wb1_ready = ~wb0_valid | force1.
//   At most one transfer per cycle, never both.
//   wait_cnt:
//     +1, saturating at MAX_WAIT, when wb1_valid & ~wb1_ready.
//     Cleared to 0 on a port-1 transfer or when wb1_valid = 0.
//   Output stage, one-cycle latency:
//     Transfer in cycle N -> RegWr/Rw/busW show it in cycle N+1.
//     The register file writes it at the edge ending N+1.
//     RegWr = 1 only if the transfer's rd != 0. A write to x0 is accepted and dropped (RegWr = 0).
//     No transfer -> RegWr = 0; Rw and busW hold their last value.
//   Scoreboard:
//     iss_ready = (iss_rd == 0) | ~pending_mask[iss_rd] | (wb1 transfer & wb1_rd == iss_rd).
//     iss_valid & iss_ready & iss_rd != 0 sets pending_mask[iss_rd].
//     A port-1 transfer clears pending_mask[wb1_rd].
//     Same rd set and cleared in the same cycle -> set wins; bit stays 1.
//     pending_mask[0] is always 0.
//     A port-1 write to a non-pending rd is legal and leaves the mask unchanged.
//   Reset (async, any time, including mid-transfer):
//     RegWr = 0, Rw = 0, busW = 0, pending_mask = 0, wait_cnt = 0.
//     An in-flight output write is discarded.
//     While rst_n = 0, ready outputs still evaluate, but no state changes.
//   The block has no FSM beyond the arbitration modes:
//     PRI0: wait_cnt < MAX_WAIT.
//     FORCE1: wait_cnt == MAX_WAIT.
//     FORCE1 -> PRI0 on a port-1 transfer or when wb1_valid drops.
// TESTING
//   Reset: rst_n low mid-write, asynchronously between edges -> RegWr = 0, Rw = 0, busW = 0, pending_mask = 0 immediately.
//   Port 0 only: rd = 5, data = 32'hDEADBEEF -> wb0_ready = 1; next cycle RegWr = 1, Rw = 5, busW = DEADBEEF; then RegWr = 0.
//   Contention, MAX_WAIT = 4, both valid every cycle:
//     port 0 granted in cycles 0-3; wb1_ready = 1 in cycle 4 only; port 1 accepted.
//     wait_cnt then returns to 0 and port 0 is granted again.
//   x0 write: wb1 rd = 0, data = 32'h1234 -> wb1_ready = 1, RegWr stays 0, pending_mask unchanged.
//   Scoreboard:
//     iss rd = 7 -> pending_mask = 32'h80 next cycle; iss_ready = 0 for rd 7.
//     Port-1 write to rd 7 -> bit 7 clears at the next edge.
//     Port-1 write to rd 7 plus re-issue of rd 7 in the same cycle -> iss_ready = 1 and bit 7 stays 1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Two writeback sources share the single register-file write port.
// Port 0 (main pipeline) has fixed priority. Port 1 (multi-cycle unit) is
// forced through after it has been refused MAX_WAIT times in a row.
// A pending mask records destination registers that still owe a port-1 write,
// so issue logic can hold back ops that would collide with them.
module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CW       = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb0_valid,
  output logic        wb0_ready,
  input  logic [4:0]  wb0_rd,
  input  logic [31:0] wb0_data,
  input  logic        wb1_valid,
  output logic        wb1_ready,
  input  logic [4:0]  wb1_rd,
  input  logic [31:0] wb1_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  output logic        RegWr,
  output logic [4:0]  Rw,
  output logic [31:0] busW,
  output logic [31:0] pending_mask
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  // Arbitration mode is fully determined by the refusal counter.
  typedef enum logic {PRI0, FORCE1} mode_e;

  logic [CW-1:0] r_wait_cnt;
  logic [CW-1:0] w_wait_next;
  mode_e         w_mode;
  logic          w_force1;
  logic          w_xfer0;
  logic          w_xfer1;
  logic [31:0]   w_set;
  logic [31:0]   w_clr;
  logic [31:0]   w_pending_next;
  logic          r_regwr;
  logic [4:0]    r_rw;
  logic [31:0]   r_busw;
  logic [31:0]   r_pending;

  // Grant logic: port 0 wins unless port 1 has waited long enough.
  always_comb begin
    w_mode    = (r_wait_cnt >= MAX_CNT) ? FORCE1 : PRI0;
    w_force1  = (w_mode == FORCE1);
    wb0_ready = ~(w_force1 & wb1_valid);
    wb1_ready = ~wb0_valid | w_force1;
    w_xfer0   = wb0_valid & wb0_ready;
    w_xfer1   = wb1_valid & wb1_ready;
  end

  // Refusal counter: counts consecutive refused port-1 cycles, saturating.
  always_comb begin
    w_wait_next = r_wait_cnt;
    if (w_xfer1 || !wb1_valid) begin
      w_wait_next = '0;
    end else if (r_wait_cnt < MAX_CNT) begin
      w_wait_next = r_wait_cnt + 1'b1;
    end
  end

  // Scoreboard: a port-1 write to the same rd does not block its re-issue,
  // and a same-cycle set overrides the clear so the new reservation survives.
  always_comb begin
    iss_ready      = (iss_rd == 5'd0) | ~r_pending[iss_rd] | (w_xfer1 & (wb1_rd == iss_rd));
    w_set          = (iss_valid && iss_ready && iss_rd != 5'd0) ? (32'd1 << iss_rd) : 32'd0;
    w_clr          = w_xfer1 ? (32'd1 << wb1_rd) : 32'd0;
    w_pending_next = ((r_pending & ~w_clr) | w_set) & ~32'd1;
  end

  // State update: counter, pending mask and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_pending  <= '0;
      r_regwr    <= 1'b0;
      r_rw       <= '0;
      r_busw     <= '0;
    end else begin
      r_wait_cnt <= w_wait_next;
      r_pending  <= w_pending_next;
      if (w_xfer0) begin
        r_regwr <= (wb0_rd != 5'd0);
        r_rw    <= wb0_rd;
        r_busw  <= wb0_data;
      end else if (w_xfer1) begin
        r_regwr <= (wb1_rd != 5'd0);
        r_rw    <= wb1_rd;
        r_busw  <= wb1_data;
      end else begin
        r_regwr <= 1'b0;
      end
    end
  end

  assign RegWr        = r_regwr;
  assign Rw           = r_rw;
  assign busW         = r_busw;
  assign pending_mask = r_pending;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed cases plus random traffic,
// checked against a behavioural model and an output scoreboard.
module tb_regfile_wb_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb0_valid, wb0_ready;
  logic [4:0]  wb0_rd;
  logic [31:0] wb0_data;
  logic        wb1_valid, wb1_ready;
  logic [4:0]  wb1_rd;
  logic [31:0] wb1_data;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_rd;
  logic        RegWr;
  logic [4:0]  Rw;
  logic [31:0] busW;
  logic [31:0] pending_mask;

  regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .RegWr(RegWr), .Rw(Rw), .busW(busW), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  int         m_wait;
  bit [31:0]  m_pend;
  logic       l_wb1_ready;

  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle out of reset, the write port must match the head
  // of the scoreboard when it is due, and be idle otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        check("RegWr", {31'd0, RegWr}, 32'd1);
        check("Rw", {27'd0, Rw}, {27'd0, e.rd});
        check("busW", busW, e.data);
        $display("write rd=%0d data=%h cycle=%0d", Rw, busW, cyc);
      end else begin
        check("RegWr idle", {31'd0, RegWr}, 32'd0);
      end
    end
  end

  // One arbitration cycle. Entered at posedge+1, leaves at the next posedge+1.
  task automatic do_cycle(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                          input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                          input logic iv, input logic [4:0] ird);
    bit force1, e0r, e1r, t0, t1, eiss;
    wb0_valid = v0; wb0_rd = rd0; wb0_data = d0;
    wb1_valid = v1; wb1_rd = rd1; wb1_data = d1;
    iss_valid = iv; iss_rd = ird;
    #1;
    force1 = (m_wait >= MAX_WAIT);
    e0r  = !(force1 && v1);
    e1r  = !v0 || force1;
    t0   = v0 && e0r;
    t1   = v1 && e1r;
    eiss = (ird == 0) || !m_pend[ird] || (t1 && rd1 == ird);
    check("wb0_ready", {31'd0, wb0_ready}, {31'd0, e0r});
    check("wb1_ready", {31'd0, wb1_ready}, {31'd0, e1r});
    check("iss_ready", {31'd0, iss_ready}, {31'd0, eiss});
    check("pending_mask", pending_mask, m_pend);
    l_wb1_ready = wb1_ready;
    if (t0 && rd0 != 0) q.push_back('{due: cyc + 1, rd: rd0, data: d0});
    if (t1 && rd1 != 0) q.push_back('{due: cyc + 1, rd: rd1, data: d1});
    if (t1) m_pend[rd1] = 1'b0;
    if (iv && eiss && ird != 0) m_pend[ird] = 1'b1;
    m_pend[0] = 1'b0;
    if (t1 || !v1) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait++;
    @(posedge clk);
    #1;
    wb0_valid = 1'b0; wb1_valid = 1'b0; iss_valid = 1'b0;
  endtask

  task automatic idle();
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_wait = 0; m_pend = '0;
    rst_n = 1'b0;
    wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
    wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
    iss_valid = 0; iss_rd = 0;

    // Readies still evaluate during reset, but nothing is written.
    repeat (2) @(posedge clk);
    #1;
    wb0_valid = 1; wb0_rd = 5'd3; wb0_data = 32'hA5A5A5A5;
    #1;
    check("reset wb0_ready", {31'd0, wb0_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("reset RegWr", {31'd0, RegWr}, 32'd0);
    check("reset Rw", {27'd0, Rw}, 32'd0);
    check("reset busW", busW, 32'd0);
    check("reset pending", pending_mask, 32'd0);
    wb0_valid = 0;
    rst_n = 1'b1;

    // Port 0 alone
    do_cycle(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    idle();
    idle();

    // Contention: port 1 forced through on the fifth cycle only
    for (int i = 0; i < 6; i++) begin
      do_cycle(1, 5'(i + 1), $urandom, 1, 5'(i + 10), $urandom, 0, 0);
      check("contention wb1_ready", {31'd0, l_wb1_ready}, (i == 4) ? 32'd1 : 32'd0);
    end
    idle();

    // Port-1 write to x0 is accepted and dropped
    do_cycle(0, 0, 0, 1, 5'd0, 32'h1234, 0, 0);
    idle();

    // Scoreboard sequence on rd 7
    do_cycle(0, 0, 0, 0, 0, 0, 1, 5'd7);
    check("pend bit7 set", pending_mask, 32'h80);
    do_cycle(0, 0, 0, 0, 0, 0, 1, 5'd7);
    do_cycle(0, 0, 0, 1, 5'd7, 32'h77, 0, 0);
    check("pend bit7 clr", pending_mask, 32'h0);
    do_cycle(0, 0, 0, 0, 0, 0, 1, 5'd7);
    do_cycle(0, 0, 0, 1, 5'd7, 32'h78, 1, 5'd7);
    check("pend set wins", pending_mask, 32'h80);
    idle();

    // Asynchronous reset while a write sits on the output stage
    do_cycle(1, 5'd9, 32'hCAFEF00D, 0, 0, 0, 0, 0);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async RegWr", {31'd0, RegWr}, 32'd0);
    check("async Rw", {27'd0, Rw}, 32'd0);
    check("async busW", busW, 32'd0);
    check("async pending", pending_mask, 32'd0);
    q.delete();
    m_wait = 0;
    m_pend = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      do_cycle($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
               $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)));
    end
    repeat (3) idle();
    check("scoreboard drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
